ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, tape-write FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter CLR_VALUE, default 8'hFF, byte written by the clear engine.
REQ-003 clk_48  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 clr_start  in  1  one-cycle pulse requesting a full 64 KiB RAM clear.
REQ-006 cpu_cs  in  1  CPU access request, valid for the current cycle.
REQ-007 cpu_we  in  1  CPU write (1) or read (0).
REQ-008 cpu_ad  in  16  CPU address.
REQ-009 cpu_d  in  8  CPU write data.
REQ-010 tape_wr  in  1  tape loader write strobe.
REQ-011 tape_addr  in  16  tape loader address.
REQ-012 tape_dout  in  8  tape loader data.
REQ-013 ram_ad  out  16  registered RAM address.
REQ-014 ram_d  out  8  registered RAM write data.
REQ-015 ram_we  out  1  registered RAM write enable.
REQ-016 cpu_ack  out  1  the CPU access was issued to RAM this cycle.
REQ-017 tape_full  out  1  FIFO is full, so tape_wr is refused.
REQ-018 tape_ovf  out  1  sticky flag: a tape write was refused.
REQ-019 clr_busy  out  1  the clear engine owns the RAM port.
REQ-020 clr_done  out  1  one-cycle pulse when the clear finishes.

Function
REQ-021 The FSM shall have two states: IDLE and CLEAR.
REQ-022 IDLE shall go to CLEAR on clr_start, with the clear counter loaded to 0; clr_busy shall go to 1 on the next edge.
REQ-023 In CLEAR the block shall drive ram_we=1, ram_ad=counter and ram_d=CLR_VALUE each cycle, then increment the counter.
REQ-024 After address 16'hFFFF is written (65536 cycles), the FSM shall return to IDLE, pulse clr_done for one cycle and drop clr_busy.
REQ-025 In CLEAR, cpu_cs shall be ignored (cpu_ack=0), and tape pushes shall continue to be accepted into the FIFO without being popped.
REQ-026 clr_start while in CLEAR shall be ignored; the clear shall not restart.
REQ-027 In IDLE the priority shall be: cpu_cs first, then a non-empty FIFO.
REQ-028 For a CPU grant, the next edge shall set ram_ad=cpu_ad, ram_d=cpu_d and ram_we=cpu_we; cpu_ack shall be asserted combinationally in the request cycle.
REQ-029 A FIFO grant (IDLE, no cpu_cs, FIFO not empty) shall pop the head entry and register ram_ad/ram_d with it and ram_we=1 on the next edge.
REQ-030 With no grant, ram_we shall be registered 0 and ram_ad/ram_d shall hold their values.
REQ-031 A push shall occur when tape_wr=1 and tape_full=0; tape_wr=1 with tape_full=1 shall drop the data and set tape_ovf.
REQ-032 tape_full shall be derived from the registered occupancy count (count==FIFO_DEPTH); a same-cycle pop shall not free space for a push in that cycle.
REQ-033 A simultaneous push and pop shall leave the count unchanged; a push to an empty FIFO shall not be poppable before the following cycle.
REQ-034 FIFO pointers shall wrap modulo FIFO_DEPTH; the count width shall be log2(FIFO_DEPTH)+1.
REQ-035 clr_start shall have priority over a simultaneous cpu_cs and FIFO pop in that cycle; cpu_ack=0 in that cycle.

Reset
REQ-036 Asserting reset shall immediately force IDLE, counter=0, an empty FIFO, and all outputs 0 except combinational cpu_ack, which follows REQ-028 in IDLE.
REQ-037 Reset during CLEAR shall abort the clear without a clr_done pulse; the partially cleared RAM is left as-is.
REQ-038 tape_ovf shall be cleared only by reset.

Configuration
REQ-039 With RAM_CLEAR_EN defined, the clear engine shall behave as in REQ-021..026 and REQ-035.
REQ-040 Without RAM_CLEAR_EN, clr_start shall be ignored, clr_busy and clr_done shall be tied 0, the FSM shall stay in IDLE, and CLR_VALUE shall be unused.

Verification
REQ-041 Clear (RAM_CLEAR_EN defined): pulse clr_start → 65536 consecutive writes of 8'hFF to addresses 0..FFFF, then clr_done high for exactly one cycle.
REQ-042 Contention: cpu_cs=1, cpu_we=1, ad=16'h0400, d=8'h55 in the same cycle as a FIFO entry (16'h0500, 8'hAA) → CPU write issued first and tape write on the next cycle.
REQ-043 Overflow: 5 back-to-back tape_wr with cpu_cs held high → 4 accepted, tape_full=1, the 5th dropped and tape_ovf=1; after cpu_cs drops, 4 writes are issued in push order.
REQ-044 Reset mid-clear: assert reset at counter 16'h1234 → outputs 0 immediately, no clr_done pulse, next clr_start restarts at address 0.
REQ-045 CPU during clear: cpu_cs=1 while clr_busy=1 → cpu_ack=0 and no CPU address appears on ram_ad.
REQ-046 Without RAM_CLEAR_EN: clr_start pulse → clr_busy stays 0 and CPU/tape arbitration is unaffected.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// This block arbitrates a single registered RAM write/read port between
// three masters:
//   - an optional RAM clear engine, which sweeps all 64 KiB with CLR_VALUE;
//   - the CPU, which is served combinationally (cpu_ack in the request cycle);
//   - a tape loader, whose writes are buffered in a small FIFO and drained
//     into RAM whenever the CPU leaves the port idle.
//
// Configuration macro:
//   RAM_CLEAR_EN  - when defined, the clear engine is built. When it is not
//                   defined, clr_start is ignored and clr_busy/clr_done are
//                   tied to 0.
//
// Parameters:
//   FIFO_DEPTH    - tape-write FIFO depth in entries (power of two, 2..16)
//   CLR_VALUE     - byte written by the clear engine
//
// Ports:
//   clk_48        in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   clr_start     in   one-cycle pulse requesting a full RAM clear
//   cpu_cs        in   CPU access request for the current cycle
//   cpu_we        in   CPU write (1) / read (0)
//   cpu_ad        in   CPU address
//   cpu_d         in   CPU write data
//   tape_wr       in   tape loader write strobe
//   tape_addr     in   tape loader address
//   tape_dout     in   tape loader data
//   ram_ad        out  registered RAM address
//   ram_d         out  registered RAM write data
//   ram_we        out  registered RAM write enable
//   cpu_ack       out  CPU access issued to RAM this cycle (combinational)
//   tape_full     out  FIFO full, tape_wr is refused
//   tape_ovf      out  sticky: a tape write was refused
//   clr_busy      out  clear engine owns the RAM port
//   clr_done      out  one-cycle pulse when the clear finishes

module ram_port_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CLR_VALUE  = 8'hFF
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        clr_start,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_d,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  output logic [15:0] ram_ad,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  output logic        cpu_ack,
  output logic        tape_full,
  output logic        tape_ovf,
  output logic        clr_busy,
  output logic        clr_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_next;
  logic [15:0] clr_cnt, clr_cnt_next;
  logic        clr_done_q, clr_done_next;
  logic        clr_go;

  logic [15:0]      fifo_ad [FIFO_DEPTH];
  logic [7:0]       fifo_d  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             grant_cpu;

  // A clear request only takes effect from IDLE, and it wins over any CPU
  // or FIFO grant in that same cycle.
`ifdef RAM_CLEAR_EN
  assign clr_go   = clr_start && (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign clr_done = clr_done_q;
`else
  logic unused_clr;
  assign clr_go     = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign unused_clr = ^{clr_start, clr_done_q};
`endif

  assign grant_cpu = cpu_cs && (state == IDLE) && !clr_go;
  assign cpu_ack   = grant_cpu;

  // Full is taken from the registered count only, so a pop in this cycle
  // never makes room for a push in the same cycle.
  assign tape_full = (count == CNT_W'(FIFO_DEPTH));
  assign push      = tape_wr && !tape_full;
  assign pop       = (state == IDLE) && !clr_go && !cpu_cs && (count != '0);

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_next;
      clr_cnt    <= clr_cnt_next;
      clr_done_q <= clr_done_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_cnt_next  = clr_cnt;
    clr_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (clr_go) begin
          state_next   = CLEAR;
          clr_cnt_next = 16'h0000;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt + 16'd1;
        // The last address written is 16'hFFFF; leave on that same edge.
        if (clr_cnt == 16'hFFFF) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM port register: clear sweep, then CPU, then FIFO head; otherwise
  // only the write enable drops and address/data hold.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      ram_ad <= '0;
      ram_d  <= '0;
      ram_we <= 1'b0;
    end else if (state == CLEAR) begin
      ram_ad <= clr_cnt;
      ram_d  <= CLR_VALUE;
      ram_we <= 1'b1;
    end else if (grant_cpu) begin
      ram_ad <= cpu_ad;
      ram_d  <= cpu_d;
      ram_we <= cpu_we;
    end else if (pop) begin
      ram_ad <= fifo_ad[rd_ptr];
      ram_d  <= fifo_d[rd_ptr];
      ram_we <= 1'b1;
    end else begin
      ram_we <= 1'b0;
    end
  end

  always_ff @(posedge clk_48) begin
    if (push) begin
      fifo_ad[wr_ptr] <= tape_addr;
      fifo_d[wr_ptr]  <= tape_dout;
    end
  end

  // Pointers are exactly PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tape_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (tape_wr && tape_full) tape_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter. Inputs are driven on the falling
// edge; registered outputs are sampled 1 ns after the rising edge and
// cpu_ack 1 ns after the inputs change. The clear-engine sequence is built
// only when RAM_CLEAR_EN is defined; otherwise clr_start is shown to have
// no effect on clr_busy or arbitration.

module tb_ram_port_arbiter;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        clr_start;
  logic        cpu_cs;
  logic        cpu_we;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_d;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic        cpu_ack;
  logic        tape_full;
  logic        tape_ovf;
  logic        clr_busy;
  logic        clr_done;

  int nChecks = 0;
  int nPass   = 0;

  ram_port_arbiter #(.FIFO_DEPTH(4), .CLR_VALUE(8'hFF)) dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .clr_start (clr_start),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_ad    (cpu_ad),
    .cpu_d     (cpu_d),
    .tape_wr   (tape_wr),
    .tape_addr (tape_addr),
    .tape_dout (tape_dout),
    .ram_ad    (ram_ad),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .cpu_ack   (cpu_ack),
    .tape_full (tape_full),
    .tape_ovf  (tape_ovf),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk_48 = ~clk_48;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic applyStimulus(input logic cs, input logic we, input logic [15:0] ad,
                               input logic [7:0] d, input logic twr,
                               input logic [15:0] taddr, input logic [7:0] tdata,
                               input logic clr);
    @(negedge clk_48);
    cpu_cs    = cs;
    cpu_we    = we;
    cpu_ad    = ad;
    cpu_d     = d;
    tape_wr   = twr;
    tape_addr = taddr;
    tape_dout = tdata;
    clr_start = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic checkPort(input string tag, input logic [15:0] ad, input logic [7:0] d, input logic we);
    checkOutput({tag, "_ad"}, {16'h0, ram_ad}, {16'h0, ad});
    checkOutput({tag, "_d"},  {24'h0, ram_d},  {24'h0, d});
    checkOutput({tag, "_we"}, {31'h0, ram_we}, {31'h0, we});
  endtask

  initial begin
    reset = 1'b1;
    clr_start = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_ad = '0; cpu_d = '0;
    tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
    #2;
    checkPort("rst", 16'h0000, 8'h00, 1'b0);
    checkOutput("rst_full", {31'h0, tape_full}, 32'h0);
    checkOutput("rst_ovf",  {31'h0, tape_ovf},  32'h0);
    checkOutput("rst_busy", {31'h0, clr_busy},  32'h0);
    checkOutput("rst_done", {31'h0, clr_done},  32'h0);
    @(negedge clk_48);
    reset = 1'b0;

    // CPU write, read, then idle hold
    applyStimulus(1, 1, 16'h1234, 8'h5A, 0, 16'h0, 8'h0, 0);
    checkOutput("cpu_ack_wr", {31'h0, cpu_ack}, 32'h1);
    tick();
    checkPort("cpu_wr", 16'h1234, 8'h5A, 1'b1);
    applyStimulus(1, 0, 16'hABCD, 8'h00, 0, 16'h0, 8'h0, 0);
    tick();
    checkPort("cpu_rd", 16'hABCD, 8'h00, 1'b0);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    checkOutput("no_ack", {31'h0, cpu_ack}, 32'h0);
    tick();
    checkPort("idle_hold", 16'hABCD, 8'h00, 1'b0);

    // Contention: tape entry queued, CPU wins, tape write next cycle
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 16'h0500, 8'hAA, 0);
    tick();
    checkOutput("push_no_pop_we", {31'h0, ram_we}, 32'h0);
    applyStimulus(1, 1, 16'h0400, 8'h55, 0, 16'h0, 8'h0, 0);
    checkOutput("cont_ack", {31'h0, cpu_ack}, 32'h1);
    tick();
    checkPort("cont_cpu", 16'h0400, 8'h55, 1'b1);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    tick();
    checkPort("cont_tape", 16'h0500, 8'hAA, 1'b1);
    tick();
    checkOutput("cont_drained_we", {31'h0, ram_we}, 32'h0);

    // Overflow: five pushes while the CPU holds the port
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 16'h0000, 8'h00, 1, 16'h1000 + 16'(i), 8'h10 + 8'(i), 0);
      if (i == 4) checkOutput("ovf_full", {31'h0, tape_full}, 32'h1);
      tick();
    end
    checkOutput("ovf_flag", {31'h0, tape_ovf}, 32'h1);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkPort($sformatf("ovf_drain%0d", i), 16'h1000 + 16'(i), 8'h10 + 8'(i), 1'b1);
    end
    tick();
    checkOutput("ovf_empty_we", {31'h0, ram_we}, 32'h0);
    checkOutput("ovf_sticky", {31'h0, tape_ovf}, 32'h1);

    // Simultaneous push and pop keeps ordering
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 16'h2000, 8'h01, 0);
    tick();
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 16'h2001, 8'h02, 0);
    tick();
    checkPort("pp_a", 16'h2000, 8'h01, 1'b1);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    tick();
    checkPort("pp_b", 16'h2001, 8'h02, 1'b1);
    tick();
    checkOutput("pp_empty_we", {31'h0, ram_we}, 32'h0);

    // Full FIFO: a pop in the same cycle does not admit a push
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 16'h0000, 8'h00, 1, 16'h3000 + 16'(i), 8'h30 + 8'(i), 0);
      tick();
    end
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 16'h3FFF, 8'hEE, 0);
    checkOutput("full_pop_full", {31'h0, tape_full}, 32'h1);
    tick();
    checkPort("full_pop0", 16'h3000, 8'h30, 1'b1);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkPort($sformatf("full_pop%0d", i), 16'h3000 + 16'(i), 8'h30 + 8'(i), 1'b1);
    end
    tick();
    checkOutput("full_drop_we", {31'h0, ram_we}, 32'h0);

`ifdef RAM_CLEAR_EN
    begin
      int errAd;
      int errAck;
      int errDone;
      int budget;
      errAd = 0; errAck = 0; errDone = 0;
      // clr_start beats a simultaneous CPU request
      applyStimulus(1, 1, 16'h4444, 8'h77, 0, 16'h0, 8'h0, 1);
      checkOutput("clr_ack_block", {31'h0, cpu_ack}, 32'h0);
      tick();
      checkOutput("clr_busy_on", {31'h0, clr_busy}, 32'h1);
      checkOutput("clr_first_we", {31'h0, ram_we}, 32'h0);
      applyStimulus(1, 1, 16'hBEEF, 8'h77, 0, 16'h0, 8'h0, 0);
      for (int i = 0; i < 65536; i++) begin
        if (cpu_ack !== 1'b0) errAck++;
        tick();
        if (ram_ad !== 16'(i) || ram_d !== 8'hFF || ram_we !== 1'b1) errAd++;
        if (i < 65535 && clr_done !== 1'b0) errDone++;
      end
      checkOutput("clr_sweep", errAd, 0);
      checkOutput("clr_cpu_ignored", errAck, 0);
      checkOutput("clr_early_done", errDone, 0);
      checkOutput("clr_done_pulse", {31'h0, clr_done}, 32'h1);
      checkOutput("clr_busy_off", {31'h0, clr_busy}, 32'h0);
      tick();
      checkOutput("clr_done_one", {31'h0, clr_done}, 32'h0);
      checkPort("clr_after_cpu", 16'hBEEF, 8'h77, 1'b1);

      // Reset mid-clear at address 16'h1234
      applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 1);
      applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
      budget = 0;
      while (ram_ad !== 16'h1234 && budget < 10000) begin
        tick();
        budget++;
      end
      checkOutput("clr_reach_1234", {16'h0, ram_ad}, 32'h1234);
      @(negedge clk_48);
      reset = 1'b1;
      #1;
      checkPort("clr_rst", 16'h0000, 8'h00, 1'b0);
      checkOutput("clr_rst_busy", {31'h0, clr_busy}, 32'h0);
      checkOutput("clr_rst_done", {31'h0, clr_done}, 32'h0);
      @(negedge clk_48);
      reset = 1'b0;
      applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 1);
      tick();
      applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
      tick();
      checkPort("clr_restart", 16'h0000, 8'hFF, 1'b1);
    end
`else
    // clr_start without the clear engine: no effect on busy or arbitration
    applyStimulus(1, 1, 16'h4444, 8'h77, 0, 16'h0, 8'h0, 1);
    checkOutput("noclr_ack", {31'h0, cpu_ack}, 32'h1);
    tick();
    checkOutput("noclr_busy", {31'h0, clr_busy}, 32'h0);
    checkPort("noclr_cpu", 16'h4444, 8'h77, 1'b1);
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 16'h5000, 8'h5C, 1);
    tick();
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 16'h0, 8'h0, 0);
    tick();
    checkPort("noclr_tape", 16'h5000, 8'h5C, 1'b1);
    checkOutput("noclr_done", {31'h0, clr_done}, 32'h0);
`endif

    // Asynchronous reset takes effect without a clock edge
    applyStimulus(1, 1, 16'h6666, 8'h66, 0, 16'h0, 8'h0, 0);
    tick();
    checkPort("pre_rst", 16'h6666, 8'h66, 1'b1);
    @(negedge clk_48);
    reset = 1'b1;
    #1;
    checkPort("async_rst", 16'h0000, 8'h00, 1'b0);
    checkOutput("async_rst_ovf", {31'h0, tape_ovf}, 32'h0);
    checkOutput("async_rst_ack", {31'h0, cpu_ack}, 32'h1);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
